// File: rtl/ops_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ops_pkg
//  Description : Shared types and constants for the ops_8bit datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package ops_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Width of an iteration counter for a w-bit operand; never narrower than 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned C_WIDTH = 8;
    localparam int unsigned C_CNT_W = cnt_width(C_WIDTH);

endpackage
`default_nettype wire

// File: rtl/mult_8x8_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_8x8_seq_if
//  Description : Start/done handshake and operand/product bus of the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_8x8_seq_if #(
    parameter int unsigned WIDTH = ops_pkg::C_WIDTH
) ();
    logic                   start_in;
    logic [WIDTH-1:0]       a_8;
    logic [WIDTH-1:0]       b_8;
    logic                   busy_out;
    logic                   done_out;
    logic [2*WIDTH-1:0]     p_16;

    modport master (
        output start_in, a_8, b_8,
        input  busy_out, done_out, p_16
    );

    modport slave (
        input  start_in, a_8, b_8,
        output busy_out, done_out, p_16
    );
endinterface
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mult_datapath
//  Description : Shift-add datapath: multiplicand/multiplier shifters, accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath
    import ops_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_load,
    input  wire logic                   i_step,
    input  wire logic [WIDTH-1:0]       i_a,
    input  wire logic [WIDTH-1:0]       i_b,
    output logic      [2*WIDTH-1:0]     o_acc_next
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;

    // Full 2*WIDTH adder; the partial products of two WIDTH-bit operands never overflow it.
    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_sum      = r_acc + w_addend;
    assign o_acc_next = w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
        end else if (i_load) begin
            r_mcand <= {{WIDTH{1'b0}}, i_a};
            r_mplr  <= i_b;
            r_acc   <= '0;
        end else if (i_step) begin
            r_acc   <= w_sum;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_8x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_8x8_seq
//  Description : Sequential unsigned shift-add multiplier, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_8x8_seq
    import ops_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH
) (
    input  wire logic           clk_in,
    input  wire logic           rst_in,
    mult_8x8_seq_if.slave       bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [2*WIDTH-1:0]     r_p;
    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [2*WIDTH-1:0]     w_acc_next;

    mult_datapath #(
        .WIDTH      (WIDTH)
    ) u_datapath (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (bus.a_8),
        .i_b        (bus.b_8),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_in) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_count == C_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start seen here chains straight into the next operation.
                if (bus.start_in) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= r_count + 1'b1;
            end
            // Capture includes the final iteration's add, not the stale accumulator.
            if (w_last) begin
                r_p <= w_acc_next;
            end
        end
    end

    assign bus.busy_out = (r_state == ST_RUN);
    assign bus.done_out = (r_state == ST_DONE);
    assign bus.p_16     = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mult_8x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_8x8_seq
//  Description : Directed self-checking bench for mult_8x8_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_8x8_seq;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    mult_8x8_seq_if #(.WIDTH(8)) bus ();

    mult_8x8_seq #(.WIDTH(8)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single start pulse, then cycle-exact check of busy, done and product.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [15:0] prev_p;
        prev_p       = bus.p_16;
        bus.start_in = 1'b1;
        bus.a_8      = a;
        bus.b_8      = b;
        @(negedge clk_in);
        bus.start_in = 1'b0;
        bus.a_8      = ~a;
        bus.b_8      = ~b;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) @(negedge clk_in);
            if (i <= 8) begin
                chk("busy_run", {31'd0, bus.busy_out}, 32'd1);
                chk("done_run", {31'd0, bus.done_out}, 32'd0);
                chk("p_held", {16'd0, bus.p_16}, {16'd0, prev_p});
            end else begin
                chk("done_pulse", {31'd0, bus.done_out}, 32'd1);
                chk("busy_done", {31'd0, bus.busy_out}, 32'd0);
                chk("product", {16'd0, bus.p_16}, {16'd0, exp});
            end
        end
        @(negedge clk_in);
        chk("done_one_cycle", {31'd0, bus.done_out}, 32'd0);
    endtask

    initial begin
        int dones;
        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd1,   8'd1,   16'h0001};
        vecs[4] = '{8'd128, 8'd2,   16'h0100};
        vecs[5] = '{8'd200, 8'd0,   16'h0000};
        vecs[6] = '{8'd17,  8'd15,  16'h00FF};
        vecs[7] = '{8'd255, 8'd1,   16'h00FF};

        bus.start_in = 1'b0;
        bus.a_8      = 8'd0;
        bus.b_8      = 8'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("rst_done", {31'd0, bus.done_out}, 32'd0);
        chk("rst_p", {16'd0, bus.p_16}, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].p);
        end

        // Start during RUN is ignored.
        bus.start_in = 1'b1;
        bus.a_8      = 8'd6;
        bus.b_8      = 8'd7;
        @(negedge clk_in);
        bus.start_in = 1'b0;
        dones        = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                bus.start_in = 1'b1;
                bus.a_8      = 8'd99;
                bus.b_8      = 8'd99;
            end else begin
                bus.start_in = 1'b0;
            end
            @(negedge clk_in);
            if (bus.done_out) begin
                dones++;
                chk("ignored_start_p", {16'd0, bus.p_16}, 32'h002A);
            end
        end
        chk("ignored_start_dones", dones, 32'd1);

        // Start held high: back-to-back, operands re-sampled at each acceptance.
        bus.start_in = 1'b1;
        bus.a_8      = 8'd3;
        bus.b_8      = 8'd5;
        @(negedge clk_in);
        bus.a_8      = 8'd10;
        bus.b_8      = 8'd10;
        for (int i = 1; i <= 18; i++) begin
            if (i > 1) @(negedge clk_in);
            if (i == 9 || i == 18) begin
                chk("b2b_done", {31'd0, bus.done_out}, 32'd1);
                chk("b2b_p", {16'd0, bus.p_16}, (i == 9) ? 32'h000F : 32'h0064);
            end else begin
                chk("b2b_busy", {31'd0, bus.busy_out}, 32'd1);
            end
        end
        bus.start_in = 1'b0;
        @(negedge clk_in);
        chk("b2b_idle_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("b2b_idle_done", {31'd0, bus.done_out}, 32'd0);

        // Reset mid-RUN aborts the operation.
        bus.start_in = 1'b1;
        bus.a_8      = 8'd200;
        bus.b_8      = 8'd3;
        @(negedge clk_in);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("abort_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("abort_done", {31'd0, bus.done_out}, 32'd0);
        chk("abort_p", {16'd0, bus.p_16}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (bus.done_out) dones++;
        end
        chk("abort_no_done", dones, 32'd0);
        run_op(8'd9, 8'd9, 16'd81);

        // Reset beats start on the same edge.
        rst_in       = 1'b1;
        bus.start_in = 1'b1;
        bus.a_8      = 8'd5;
        bus.b_8      = 8'd5;
        @(negedge clk_in);
        rst_in       = 1'b0;
        bus.start_in = 1'b0;
        chk("rst_start_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("rst_start_p", {16'd0, bus.p_16}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (bus.done_out || bus.busy_out) dones++;
        end
        chk("rst_start_no_op", dones, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
